sa_request_credit_manager: RTL and testbench
============================================

Name: sa_request_credit_manager

Overview:
- Feeds the switch allocator of each router.
- Builds the per-input request matrix from head-of-queue flit destinations, masked by downstream credit availability and wormhole output ownership.
- Consumes the allocator's grant matrix in the same cycle: pops granted flits, decrements output credits, and maintains the output lock until the tail flit is sent.
- Sits between the input buffers and the separable input-first switch allocator.

Parameters:
- AGENTS_NUM, 5, number of input ports (allocator agents).
- RESOURCES_NUM, 5, number of output ports (allocator resources).
- CREDITS_MAX, 4, downstream buffer depth per output, in flits; must be at least 1.
- Derived: RESOURCES_PTR_SIZE = $clog2(RESOURCES_NUM), AGENTS_PTR_SIZE = $clog2(AGENTS_NUM), CREDIT_W = $clog2(CREDITS_MAX+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  [AGENTS_NUM]  input i has a flit at head of queue.
- out_port_i  input  [AGENTS_NUM][RESOURCES_PTR_SIZE]  destination output of head flit i.
- is_tail_i  input  [AGENTS_NUM]  head flit i is a tail flit (single-flit packets are tail).
- requests_o  output  [AGENTS_NUM][RESOURCES_NUM]  request matrix to allocator requests_i.
- grants_i  input  [AGENTS_NUM][RESOURCES_NUM]  grant matrix from allocator grants_o, same cycle.
- credit_return_i  input  [RESOURCES_NUM]  downstream freed one slot of output o.
- flit_sent_o  output  [AGENTS_NUM]  input i pops its head flit this cycle.
- credits_o  output  [RESOURCES_NUM][CREDIT_W]  registered credit count per output.
- locked_o  output  [RESOURCES_NUM]  output o is held by a packet in flight.
- error_o  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset, synchronous: every credits_o = CREDITS_MAX, locked_o = 0, owner = 0, error_o = 0.
- Reset mid-packet discards all lock and credit state. requests_o and flit_sent_o are 0 while rst = 1.
- Request generation is combinational from inputs and registered state:
  - requests_o[i][o] = valid_i[i] & (out_port_i[i]==o) & (credits[o]!=0) & (!locked[o] | owner[o]==i).
  - At most one bit is set per row.
  - out_port_i >= RESOURCES_NUM produces no request.
- Grant handling:
  - Effective grant g[i][o] = grants_i[i][o] & requests_o[i][o]. Spurious grant bits are ignored.
  - flit_sent_o[i] = |g[i], combinational, zero latency from grants_i.
- Credit update per output o, registered: next = credits[o] - (|g[*][o]) + credit_return_i[o].
  - Grant and return in the same cycle leave the count unchanged.
  - Return at CREDITS_MAX with no grant saturates at CREDITS_MAX.
  - A grant at 0 credits is impossible because the request is masked.
- Per-output lock FSM, registered, two states:
  - IDLE -> LOCKED(owner=i) on an effective grant from i with is_tail_i[i]=0.
  - LOCKED(i) -> IDLE on an effective grant from i with is_tail_i[i]=1.
  - IDLE + tail grant (single-flit packet) -> stays IDLE.
  - While LOCKED, requests to o from non-owners are masked.
  - If the owner's head flit changes destination while locked, no request is generated and the lock holds.
- If more than one bit is set in a column of g (allocator misbehaviour): the lowest-index agent wins for lock purposes, and credit decrements by 1 only.

Optional Feature:
- Macro SA_CREDIT_CHECK_EN.
- When defined, error_o is set and held until rst on any of:
  - credit_return_i[o] with credits[o]==CREDITS_MAX and no grant to o;
  - grants_i bit not present in requests_o;
  - more than one grant in a column of grants_i.
- When defined, the raw grant matrix is also checked, so spurious bits flag an error before masking.
- When undefined, error_o is tied to 0, no checking logic is synthesized, and the saturation and masking behaviour above is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> credits_o all 4, locked_o=0, error_o=0, requests_o=0 with valid_i=0.
- Single-flit packet: valid_i[1]=1, out_port_i[1]=3, is_tail=1, grant [1][3] -> flit_sent_o[1]=1 the same cycle; credits_o[3]=3 the next cycle; locked_o[3] stays 0.
- Credit exhaustion: 4 back-to-back grants to output 2 with no returns -> credits_o[2]=0 and requests_o[*][2]=0. One credit_return_i[2] -> credits_o[2]=1 and the request reappears.
- Wormhole lock: input 0 sends a head (tail=0) to output 4 -> locked_o[4]=1. Input 2 targeting 4 gets requests_o[2][4]=0 until input 0's tail grant; the cycle after, locked_o[4]=0 and requests_o[2][4]=1.
- Simultaneous grant and return on output 1 at credits=2 -> credits stay 2. Return at credits=4 -> stays 4, and error_o=1 only with SA_CREDIT_CHECK_EN.
- Spurious grant: grants_i[3][0]=1 with requests_o[3][0]=0 -> flit_sent_o[3]=0, credits unchanged, error_o=1 only with SA_CREDIT_CHECK_EN.

Source files
------------

// File: rtl/sa_request_credit_manager.sv
// rtl/sa_request_credit_manager.sv - switch-allocator request, credit and wormhole-lock manager
//
// Purpose: builds the per-input request matrix from head-flit destinations,
// masks it by downstream credits and wormhole output ownership, then consumes
// the allocator grant matrix in the same cycle (pop, credit decrement, lock).
//
// Ports:
//   clk             - clock, rising edge
//   rst             - synchronous active-high reset
//   valid_i         - [AGENTS_NUM] head flit present per input
//   out_port_i      - [AGENTS_NUM][RESOURCES_PTR_SIZE] head flit destination
//   is_tail_i       - [AGENTS_NUM] head flit is a tail flit
//   requests_o      - [AGENTS_NUM][RESOURCES_NUM] request matrix to allocator
//   grants_i        - [AGENTS_NUM][RESOURCES_NUM] grant matrix from allocator
//   credit_return_i - [RESOURCES_NUM] downstream freed one slot
//   flit_sent_o     - [AGENTS_NUM] input pops its head flit this cycle
//   credits_o       - [RESOURCES_NUM][CREDIT_W] registered credit counts
//   locked_o        - [RESOURCES_NUM] output held by a packet in flight
//   error_o         - sticky protocol error
//
// Optional feature: define SA_CREDIT_CHECK_EN to enable protocol checking on
// error_o; without it error_o is tied to 0.
module sa_request_credit_manager #(
  parameter int AGENTS_NUM         = 5,
  parameter int RESOURCES_NUM      = 5,
  parameter int CREDITS_MAX        = 4,
  parameter int RESOURCES_PTR_SIZE = (RESOURCES_NUM > 1) ? $clog2(RESOURCES_NUM) : 1,
  parameter int AGENTS_PTR_SIZE    = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1,
  parameter int CREDIT_W           = $clog2(CREDITS_MAX + 1)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [AGENTS_NUM-1:0]                            valid_i,
  input  logic [AGENTS_NUM-1:0][RESOURCES_PTR_SIZE-1:0]    out_port_i,
  input  logic [AGENTS_NUM-1:0]                            is_tail_i,
  output logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]         requests_o,
  input  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]         grants_i,
  input  logic [RESOURCES_NUM-1:0]                         credit_return_i,
  output logic [AGENTS_NUM-1:0]                            flit_sent_o,
  output logic [RESOURCES_NUM-1:0][CREDIT_W-1:0]           credits_o,
  output logic [RESOURCES_NUM-1:0]                         locked_o,
  output logic                                             error_o
);

  typedef enum logic {LK_IDLE = 1'b0, LK_LOCKED = 1'b1} lock_state_t;

  lock_state_t                                   r_state     [RESOURCES_NUM];
  lock_state_t                                   w_state_nxt [RESOURCES_NUM];
  logic [RESOURCES_NUM-1:0][AGENTS_PTR_SIZE-1:0] r_owner;
  logic [RESOURCES_NUM-1:0][AGENTS_PTR_SIZE-1:0] w_owner_nxt;
  logic [RESOURCES_NUM-1:0][CREDIT_W-1:0]        r_credits;
  logic [RESOURCES_NUM-1:0][CREDIT_W-1:0]        w_credits_nxt;
  logic [CREDIT_W:0]                             w_credit_sum;
  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]      w_req;
  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]      w_grant;
  logic [RESOURCES_NUM-1:0]                      w_col_any;
  logic [RESOURCES_NUM-1:0]                      w_col_tail;
  logic [RESOURCES_NUM-1:0][AGENTS_PTR_SIZE-1:0] w_col_agent;

  // A destination outside 0..RESOURCES_NUM-1 never matches any column, so it
  // produces no request.
  always_comb begin : request_gen
    w_req = '0;
    for (int i = 0; i < AGENTS_NUM; i++) begin
      for (int o = 0; o < RESOURCES_NUM; o++) begin
        w_req[i][o] = !rst && valid_i[i]
                    && (out_port_i[i] == RESOURCES_PTR_SIZE'(o))
                    && (r_credits[o] != '0)
                    && ((r_state[o] == LK_IDLE) || (r_owner[o] == AGENTS_PTR_SIZE'(i)));
      end
    end
  end

  assign requests_o = w_req;
  // Grant bits without a matching request are dropped here.
  assign w_grant    = grants_i & w_req;

  always_comb begin : sent_gen
    flit_sent_o = '0;
    for (int i = 0; i < AGENTS_NUM; i++) begin
      flit_sent_o[i] = |w_grant[i];
    end
  end

  // Scan from the highest index down so the lowest-index granted agent is the
  // one that survives when the allocator grants a column twice.
  always_comb begin : column_scan
    w_col_any   = '0;
    w_col_tail  = '0;
    w_col_agent = '0;
    for (int o = 0; o < RESOURCES_NUM; o++) begin
      for (int i = AGENTS_NUM - 1; i >= 0; i--) begin
        if (w_grant[i][o]) begin
          w_col_any[o]   = 1'b1;
          w_col_tail[o]  = is_tail_i[i];
          w_col_agent[o] = AGENTS_PTR_SIZE'(i);
        end
      end
    end
  end

  // Lock FSM next state: while locked only the owner can hold an effective
  // grant, so the same rule covers both the acquire and the release.
  always_comb begin : lock_next
    for (int o = 0; o < RESOURCES_NUM; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      if (w_col_any[o]) begin
        if (w_col_tail[o]) begin
          w_state_nxt[o] = LK_IDLE;
        end else begin
          w_state_nxt[o] = LK_LOCKED;
          w_owner_nxt[o] = w_col_agent[o];
        end
      end
    end
  end

  always_comb begin : lock_out
    locked_o = '0;
    for (int o = 0; o < RESOURCES_NUM; o++) begin
      locked_o[o] = (r_state[o] == LK_LOCKED);
    end
  end

  // One extra bit of headroom so a return at full credit can be clamped.
  always_comb begin : credit_next
    w_credit_sum  = '0;
    w_credits_nxt = r_credits;
    for (int o = 0; o < RESOURCES_NUM; o++) begin
      w_credit_sum = {1'b0, r_credits[o]}
                   - {{CREDIT_W{1'b0}}, w_col_any[o]}
                   + {{CREDIT_W{1'b0}}, credit_return_i[o]};
      if (w_credit_sum > (CREDIT_W + 1)'(CREDITS_MAX)) begin
        w_credits_nxt[o] = CREDIT_W'(CREDITS_MAX);
      end else begin
        w_credits_nxt[o] = w_credit_sum[CREDIT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < RESOURCES_NUM; o++) begin
        r_state[o]   <= LK_IDLE;
        r_owner[o]   <= '0;
        r_credits[o] <= CREDIT_W'(CREDITS_MAX);
      end
    end else begin
      for (int o = 0; o < RESOURCES_NUM; o++) begin
        r_state[o] <= w_state_nxt[o];
      end
      r_owner   <= w_owner_nxt;
      r_credits <= w_credits_nxt;
    end
  end

  assign credits_o = r_credits;

`ifdef SA_CREDIT_CHECK_EN
  logic                     r_error;
  logic                     w_err_now;
  logic [RESOURCES_NUM-1:0] w_seen;

  // Checks look at the raw grant matrix, before spurious bits are masked.
  always_comb begin : protocol_check
    w_err_now = |(grants_i & ~w_req);
    w_seen    = '0;
    for (int o = 0; o < RESOURCES_NUM; o++) begin
      for (int i = 0; i < AGENTS_NUM; i++) begin
        if (grants_i[i][o] && w_seen[o]) begin
          w_err_now = 1'b1;
        end
        if (grants_i[i][o]) begin
          w_seen[o] = 1'b1;
        end
      end
      if (credit_return_i[o] && (r_credits[o] == CREDIT_W'(CREDITS_MAX)) && !w_col_any[o]) begin
        w_err_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (w_err_now) begin
      r_error <= 1'b1;
    end
  end

  assign error_o = r_error;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_sa_request_credit_manager.sv
// tb/tb_sa_request_credit_manager.sv - self-checking bench for sa_request_credit_manager
module tb_sa_request_credit_manager;

  localparam int NA   = 5;
  localparam int NR   = 5;
  localparam int CMAX = 4;
`ifdef SA_CREDIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NA-1:0]          valid_i;
  logic [NA-1:0][2:0]     out_port_i;
  logic [NA-1:0]          is_tail_i;
  logic [NA-1:0][NR-1:0]  requests_o;
  logic [NA-1:0][NR-1:0]  grants_i;
  logic [NR-1:0]          credit_return_i;
  logic [NA-1:0]          flit_sent_o;
  logic [NR-1:0][2:0]     credits_o;
  logic [NR-1:0]          locked_o;
  logic                   error_o;

  sa_request_credit_manager dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .out_port_i      (out_port_i),
    .is_tail_i       (is_tail_i),
    .requests_o      (requests_o),
    .grants_i        (grants_i),
    .credit_return_i (credit_return_i),
    .flit_sent_o     (flit_sent_o),
    .credits_o       (credits_o),
    .locked_o        (locked_o),
    .error_o         (error_o)
  );

  always #5 clk = ~clk;

  // One table row: up to two active agents. a0 may be driven invalid (v0=0)
  // to present a spurious grant; g* = granted output or -1. Expected state
  // (cv on output co, lk, ee) is the registered state seen during the row.
  typedef struct {
    int a0; bit v0; int p0; bit t0; int g0;
    int a1; int p1; bit t1; int g1;
    int ret;
    bit r0; bit r1; bit s0; bit s1;
    int co; int cv; logic [4:0] lk; bit ee;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [NA-1:0][NR-1:0] exp_req;
  logic [NA-1:0]         exp_sent;
  int                    m_cred [NR];
  int                    m_own  [NR];
  bit                    m_err;
  int                    cand[$];
  int                    lo;
  int                    cnt_raw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input vec_t v);
    vecs.push_back(v);
  endfunction

  task automatic idle();
    valid_i         = '0;
    out_port_i      = '0;
    is_tail_i       = '0;
    grants_i        = '0;
    credit_return_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input int k, input vec_t v);
    @(negedge clk);
    idle();
    exp_req  = '0;
    exp_sent = '0;
    if (v.a0 >= 0) begin
      valid_i[v.a0]    = v.v0;
      out_port_i[v.a0] = 3'(v.p0);
      is_tail_i[v.a0]  = v.t0;
      if (v.g0 >= 0) grants_i[v.a0][v.g0] = 1'b1;
      if (v.r0) exp_req[v.a0][v.p0] = 1'b1;
      exp_sent[v.a0] = v.s0;
    end
    if (v.a1 >= 0) begin
      valid_i[v.a1]    = 1'b1;
      out_port_i[v.a1] = 3'(v.p1);
      is_tail_i[v.a1]  = v.t1;
      if (v.g1 >= 0) grants_i[v.a1][v.g1] = 1'b1;
      if (v.r1) exp_req[v.a1][v.p1] = 1'b1;
      exp_sent[v.a1] = v.s1;
    end
    if (v.ret >= 0) credit_return_i[v.ret] = 1'b1;
    #1;
    chk($sformatf("row%0d_req", k), 32'(requests_o), 32'(exp_req));
    chk($sformatf("row%0d_sent", k), 32'(flit_sent_o), 32'(exp_sent));
    chk($sformatf("row%0d_credit%0d", k, v.co), 32'(credits_o[v.co]), 32'(v.cv));
    chk($sformatf("row%0d_locked", k), 32'(locked_o), 32'(v.lk));
    chk($sformatf("row%0d_error", k), 32'(error_o), 32'(CHK_EN & v.ee));
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // single-flit packet 1 -> 3
    add(vec_t'{1,1,3,1,3, -1,0,0,-1, -1, 1,0,1,0, 3,4,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, -1, 0,0,0,0, 3,3,5'h00,0});
    // credit exhaustion on output 2, then refill
    add(vec_t'{4,1,2,1,2, -1,0,0,-1, -1, 1,0,1,0, 2,4,5'h00,0});
    add(vec_t'{4,1,2,1,2, -1,0,0,-1, -1, 1,0,1,0, 2,3,5'h00,0});
    add(vec_t'{4,1,2,1,2, -1,0,0,-1, -1, 1,0,1,0, 2,2,5'h00,0});
    add(vec_t'{4,1,2,1,2, -1,0,0,-1, -1, 1,0,1,0, 2,1,5'h00,0});
    add(vec_t'{4,1,2,1,-1, -1,0,0,-1, -1, 0,0,0,0, 2,0,5'h00,0});
    add(vec_t'{4,1,2,1,-1, -1,0,0,-1, 2, 0,0,0,0, 2,0,5'h00,0});
    add(vec_t'{4,1,2,1,-1, -1,0,0,-1, -1, 1,0,0,0, 2,1,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 2, 0,0,0,0, 2,1,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 2, 0,0,0,0, 2,2,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 2, 0,0,0,0, 2,3,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, -1, 0,0,0,0, 2,4,5'h00,0});
    // wormhole lock on output 4, input 2 blocked until tail
    add(vec_t'{0,1,4,0,4, 2,4,1,-1, -1, 1,1,1,0, 4,4,5'h00,0});
    add(vec_t'{0,1,4,0,4, 2,4,1,-1, -1, 1,0,1,0, 4,3,5'h10,0});
    add(vec_t'{0,1,4,1,4, 2,4,1,-1, -1, 1,0,1,0, 4,2,5'h10,0});
    add(vec_t'{-1,0,0,0,-1, 2,4,1,-1, -1, 0,1,0,0, 4,1,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 4, 0,0,0,0, 4,1,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 4, 0,0,0,0, 4,2,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 4, 0,0,0,0, 4,3,5'h00,0});
    // owner changes destination while locked: lock holds
    add(vec_t'{0,1,4,0,4, -1,0,0,-1, -1, 1,0,1,0, 4,4,5'h00,0});
    add(vec_t'{0,1,1,0,-1, 2,4,1,-1, -1, 1,0,0,0, 4,3,5'h10,0});
    add(vec_t'{0,1,4,1,4, 2,4,1,-1, -1, 1,0,1,0, 4,3,5'h10,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 4, 0,0,0,0, 4,2,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 4, 0,0,0,0, 4,3,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, -1, 0,0,0,0, 4,4,5'h00,0});
    // output 1: grant+return at 2 holds, then return at full saturates
    add(vec_t'{1,1,1,1,1, -1,0,0,-1, -1, 1,0,1,0, 1,4,5'h00,0});
    add(vec_t'{1,1,1,1,1, -1,0,0,-1, -1, 1,0,1,0, 1,3,5'h00,0});
    add(vec_t'{1,1,1,1,1, -1,0,0,-1, 1, 1,0,1,0, 1,2,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, -1, 0,0,0,0, 1,2,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 1, 0,0,0,0, 1,2,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 1, 0,0,0,0, 1,3,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, 1, 0,0,0,0, 1,4,5'h00,0});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, -1, 0,0,0,0, 1,4,5'h00,1});
    // spurious grant [3][0]
    add(vec_t'{3,0,0,0,0, -1,0,0,-1, -1, 0,0,0,0, 0,4,5'h00,1});
    add(vec_t'{-1,0,0,0,-1, -1,0,0,-1, -1, 0,0,0,0, 0,4,5'h00,1});

    do_reset();
    #1;
    chk("reset_credits", 32'(credits_o), 32'h4924);
    chk("reset_locked", 32'(locked_o), 32'h0);
    chk("reset_error", 32'(error_o), 32'h0);
    chk("reset_requests", 32'(requests_o), 32'h0);

    for (int k = 0; k < vecs.size(); k++) apply(k, vecs[k]);

    // spurious grant alone after a clean reset
    do_reset();
    #1;
    chk("h_spur_pre_error", 32'(error_o), 32'h0);
    @(negedge clk);
    idle();
    grants_i[3][0] = 1'b1;
    #1;
    chk("h_spur_sent", 32'(flit_sent_o), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("h_spur_credit", 32'(credits_o[0]), 32'd4);
    chk("h_spur_error", 32'(error_o), 32'(CHK_EN));

    // double grant in column 3: lowest agent owns, one credit consumed
    do_reset();
    @(negedge clk);
    idle();
    valid_i        = 5'b00101;
    out_port_i[0]  = 3'd3;
    out_port_i[2]  = 3'd3;
    grants_i[0][3] = 1'b1;
    grants_i[2][3] = 1'b1;
    #1;
    chk("h_dbl_sent", 32'(flit_sent_o), 32'h05);
    @(negedge clk);
    grants_i = '0;
    #1;
    chk("h_dbl_credit", 32'(credits_o[3]), 32'd3);
    chk("h_dbl_locked", 32'(locked_o), 32'h08);
    chk("h_dbl_req", 32'(requests_o), 32'h0008);
    chk("h_dbl_error", 32'(error_o), 32'(CHK_EN));

    // reset mid-packet drops the lock and restores credits
    @(negedge clk);
    rst            = 1'b1;
    grants_i[0][3] = 1'b1;
    #1;
    chk("h_rst_req", 32'(requests_o), 32'h0);
    chk("h_rst_sent", 32'(flit_sent_o), 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    grants_i = '0;
    #1;
    chk("h_rst_locked", 32'(locked_o), 32'h0);
    chk("h_rst_credit", 32'(credits_o[3]), 32'd4);
    chk("h_rst_error", 32'(error_o), 32'h0);
    chk("h_rst_req_after", 32'(requests_o), 32'h2008);

    // randomized run against a reference model
    do_reset();
    for (int o = 0; o < NR; o++) begin
      m_cred[o] = CMAX;
      m_own[o]  = -1;
    end
    m_err = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      valid_i   = 5'($urandom);
      is_tail_i = '0;
      for (int i = 0; i < NA; i++) begin
        out_port_i[i] = 3'($urandom_range(0, 6));
        is_tail_i[i]  = ($urandom_range(0, 2) == 0);
      end
      exp_req = '0;
      for (int i = 0; i < NA; i++)
        for (int o = 0; o < NR; o++)
          exp_req[i][o] = !rst && valid_i[i] && (int'(out_port_i[i]) == o) && (m_cred[o] > 0)
                          && (m_own[o] < 0 || m_own[o] == i);
      grants_i = '0;
      for (int o = 0; o < NR; o++) begin
        cand.delete();
        for (int i = 0; i < NA; i++) if (exp_req[i][o]) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 3) != 0)
          grants_i[cand[$urandom_range(0, cand.size() - 1)]][o] = 1'b1;
        if ($urandom_range(0, 24) == 0) grants_i[$urandom_range(0, NA - 1)][o] = 1'b1;
      end
      credit_return_i = '0;
      for (int o = 0; o < NR; o++) credit_return_i[o] = ($urandom_range(0, 2) == 0);
      exp_sent = '0;
      for (int i = 0; i < NA; i++) exp_sent[i] = |(grants_i[i] & exp_req[i]);
      #1;
      chk($sformatf("rnd%0d_req", cyc), 32'(requests_o), 32'(exp_req));
      chk($sformatf("rnd%0d_sent", cyc), 32'(flit_sent_o), 32'(exp_sent));
      for (int o = 0; o < NR; o++) begin
        chk($sformatf("rnd%0d_credit%0d", cyc, o), 32'(credits_o[o]), 32'(m_cred[o]));
        chk($sformatf("rnd%0d_locked%0d", cyc, o), 32'(locked_o[o]), 32'(m_own[o] >= 0));
      end
      chk($sformatf("rnd%0d_error", cyc), 32'(error_o), 32'(CHK_EN && m_err));
      if (rst) begin
        for (int o = 0; o < NR; o++) begin
          m_cred[o] = CMAX;
          m_own[o]  = -1;
        end
        m_err = 1'b0;
      end else begin
        for (int o = 0; o < NR; o++) begin
          lo      = -1;
          cnt_raw = 0;
          for (int i = 0; i < NA; i++) begin
            if (grants_i[i][o]) cnt_raw++;
            if (grants_i[i][o] && !exp_req[i][o]) m_err = 1'b1;
            if (grants_i[i][o] && exp_req[i][o] && lo < 0) lo = i;
          end
          if (cnt_raw > 1) m_err = 1'b1;
          if (credit_return_i[o] && m_cred[o] == CMAX && lo < 0) m_err = 1'b1;
          if (lo >= 0) begin
            m_cred[o] = m_cred[o] - 1;
            m_own[o]  = is_tail_i[lo] ? -1 : lo;
          end
          if (credit_return_i[o] && m_cred[o] < CMAX) m_cred[o] = m_cred[o] + 1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
